latch_gate_arbiter: RTL and testbench
=====================================

LATCH_GATE_ARBITER -- requirements
Module: latch_gate_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8: data width of the shared gated-D-latch bank.
REQ-003 SHALL have parameter SETUP_CYC, default 1: number of cycles latch_d is stable before the gate opens (>=1).
REQ-004 SHALL have parameter GATE_CYC, default 2: number of cycles latch_en is high (>=1).
REQ-005 SHALL have parameter HOLD_CYC, default 1: number of cycles latch_d is stable after the gate closes (>=1).
REQ-006 SHALL have one clock; reset is synchronous and active-low (ports clk, rst_n).
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst_n  input  1  synchronous active-low reset.
REQ-009 req  input  N_REQ  write request, one bit per requester.
REQ-010 wdata  input  N_REQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-011 gnt  output  N_REQ  one-hot grant, held for the whole transaction.
REQ-012 done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-013 latch_d  output  WIDTH  registered data driven to the latch bank d inputs.
REQ-014 latch_en  output  1  registered gate driven to the latch bank clk (gate) input.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 SHALL implement an FSM with states IDLE, SETUP, GATE, HOLD and a phase counter sized for max(SETUP_CYC, GATE_CYC, HOLD_CYC).
REQ-017 IDLE with req==0: remain in IDLE; gnt=0, latch_en=0, done=0, latch_d holds its last value.
REQ-018 IDLE with any req bit set: choose the round-robin winner, searching from pointer ptr upward with wrap; on the next edge enter SETUP, set gnt to the winner's one-hot code, capture the winner's wdata slice into latch_d, and set ptr=(winner+1) mod N_REQ.
REQ-019 SETUP lasts exactly SETUP_CYC cycles with latch_en=0, then moves to GATE.
REQ-020 GATE lasts exactly GATE_CYC cycles with latch_en=1, then moves to HOLD.
REQ-021 HOLD lasts exactly HOLD_CYC cycles with latch_en=0; done[winner]=1 in the last HOLD cycle only; then moves to IDLE.
REQ-022 gnt stays constant from the first SETUP cycle through the last HOLD cycle and is 0 in IDLE.
REQ-023 latch_d stays constant from SETUP through HOLD; wdata changes after capture are ignored.
REQ-024 latch_en is never high outside GATE and never changes on the same edge as latch_d.
REQ-025 Deassertion of req by the granted requester mid-transaction is ignored; the transaction completes and done still pulses.
REQ-026 Requests arriving outside IDLE are not lost while held; they are arbitrated at the next IDLE cycle.
REQ-027 One IDLE cycle always separates transactions; the per-transaction period is SETUP_CYC+GATE_CYC+HOLD_CYC+1 cycles (5 with defaults).
REQ-028 A requester holding req after its done pulse gets lowest priority at the next arbitration (fairness through ptr).
REQ-029 gnt and done are always one-hot or zero; done is a subset of gnt.

Reset
REQ-030 While rst_n=0 at a rising edge: state=IDLE, counter=0, ptr=0, gnt=0, done=0, latch_en=0, latch_d=0, busy=0.
REQ-031 Reset asserted mid-transaction, including during GATE, SHALL force latch_en=0 at that edge; the aborted requester receives no done pulse.

Verification
REQ-032 Hold rst_n=0 for 2 cycles with random req/wdata -> all outputs are 0 and busy=0.
REQ-033 Pulse req=4'b0100 with wdata[23:16]=8'hA5 at cycle 0 (defaults) -> gnt=4'b0100 in cycles 1-4, latch_d=8'hA5 in cycles 1-4, latch_en=1 in cycles 2-3, done=4'b0100 in cycle 4 only, IDLE in cycle 5.
REQ-034 Hold req=4'b1111 continuously -> grant order 0,1,2,3,0, with a new grant every 5 cycles and no requester skipped.
REQ-035 Grant req[1], drop req[1] in SETUP and change wdata[15:8] during GATE -> transaction completes, latch_d unchanged, done[1] pulses once.
REQ-036 Drive rst_n=0 on the first GATE cycle -> next edge latch_en=0, gnt=0, done stays 0, ptr=0; the next request from requester 0 wins first.
REQ-037 Hold req=4'b1001 with ptr=1 -> requester 3 is granted before requester 0.

Source files
------------

// File: rtl/latch_gate_arbiter.sv
// latch_gate_arbiter: round-robin arbiter driving a shared gated-D-latch bank with setup/gate/hold sequencing
module latch_gate_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int GATE_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [WIDTH-1:0]       latch_d,
  output logic                   latch_en,
  output logic                   busy
);
  localparam int MAXC = (SETUP_CYC > GATE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                               : ((GATE_CYC > HOLD_CYC) ? GATE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAXC + 1);
  localparam int PW = $clog2(N_REQ);
  localparam logic [CW-1:0] S_END = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] G_END = CW'(GATE_CYC - 1);
  localparam logic [CW-1:0] H_END = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] H_PRE = CW'((HOLD_CYC > 1) ? HOLD_CYC - 2 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, GATE, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;

  assign busy = state != IDLE;

  // round-robin pick: scan from ptr upward with wrap, nearest requester wins
  always_comb begin
    win = ptr;
    idx = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (req[idx]) win = idx;
    end
  end

  // transaction sequencer: capture data, then gate the latch, then hold and report completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      gnt      <= '0;
      done     <= '0;
      latch_en <= 1'b0;
      latch_d  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (|req) begin
            state   <= SETUP;
            cnt     <= '0;
            gnt     <= N_REQ'(1) << win;
            latch_d <= wdata[int'(win)*WIDTH +: WIDTH];
            ptr     <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
          end
        end
        SETUP: begin
          cnt      <= (cnt == S_END) ? '0 : cnt + 1'b1;
          state    <= (cnt == S_END) ? GATE : SETUP;
          latch_en <= cnt == S_END;
        end
        GATE: begin
          cnt      <= (cnt == G_END) ? '0 : cnt + 1'b1;
          state    <= (cnt == G_END) ? HOLD : GATE;
          latch_en <= cnt != G_END;
          done     <= (cnt == G_END && HOLD_CYC == 1) ? gnt : '0;
        end
        HOLD: begin
          cnt   <= (cnt == H_END) ? '0 : cnt + 1'b1;
          state <= (cnt == H_END) ? IDLE : HOLD;
          gnt   <= (cnt == H_END) ? '0 : gnt;
          done  <= (cnt != H_END && cnt == H_PRE) ? gnt : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_latch_gate_arbiter.sv
// tb_latch_gate_arbiter: table-driven and sequence checks for latch_gate_arbiter at default parameters
module tb_latch_gate_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [7:0]  latch_d;
  logic        latch_en;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rn;
    logic [3:0]  rq;
    logic [31:0] wd;
    logic [3:0]  g;
    logic [3:0]  d;
    logic [7:0]  ld;
    logic        en;
    logic        bz;
  } vec_t;

  vec_t v[$];

  latch_gate_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .done(done), .latch_d(latch_d), .latch_en(latch_en), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic step(input logic rn, input logic [3:0] rq, input logic [31:0] wd);
    rst_n = rn;
    req   = rq;
    wdata = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rn, input logic [3:0] rq, input logic [31:0] wd, input logic [3:0] g,
                     input logic [3:0] d, input logic [7:0] ld, input logic en, input logic bz);
    v.push_back('{rn, rq, wd, g, d, ld, en, bz});
  endtask

  initial begin
    int n;
    logic [3:0] prev;
    logic [3:0] exp_g;
    rst_n = 1'b0;
    req   = '0;
    wdata = '0;
    //  rn  req   wdata          gnt   done  ld     en    busy
    add(0, 4'hF, 32'hDEADBEEF, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    add(0, 4'hA, 32'h12345678, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    add(1, 4'h4, 32'h00A50000, 4'h4, 4'h0, 8'hA5, 1'b0, 1'b1);
    add(1, 4'h0, 32'h00000000, 4'h4, 4'h0, 8'hA5, 1'b1, 1'b1);
    add(1, 4'h0, 32'h00000000, 4'h4, 4'h0, 8'hA5, 1'b1, 1'b1);
    add(1, 4'h0, 32'h00000000, 4'h4, 4'h4, 8'hA5, 1'b0, 1'b1);
    add(1, 4'h0, 32'h00000000, 4'h0, 4'h0, 8'hA5, 1'b0, 1'b0);
    add(1, 4'h0, 32'h00000000, 4'h0, 4'h0, 8'hA5, 1'b0, 1'b0);
    add(1, 4'h2, 32'h00003C00, 4'h2, 4'h0, 8'h3C, 1'b0, 1'b1);
    add(1, 4'h0, 32'h00003C00, 4'h2, 4'h0, 8'h3C, 1'b1, 1'b1);
    add(1, 4'h0, 32'h0000FF00, 4'h2, 4'h0, 8'h3C, 1'b1, 1'b1);
    add(1, 4'h0, 32'h0000FF00, 4'h2, 4'h2, 8'h3C, 1'b0, 1'b1);
    add(1, 4'h0, 32'h00000000, 4'h0, 4'h0, 8'h3C, 1'b0, 1'b0);
    add(1, 4'h4, 32'h00770000, 4'h4, 4'h0, 8'h77, 1'b0, 1'b1);
    add(1, 4'h0, 32'h00000000, 4'h4, 4'h0, 8'h77, 1'b1, 1'b1);
    add(0, 4'h0, 32'h00000000, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    add(1, 4'h9, 32'h44000022, 4'h1, 4'h0, 8'h22, 1'b0, 1'b1);
    add(1, 4'h9, 32'h44000022, 4'h1, 4'h0, 8'h22, 1'b1, 1'b1);
    add(1, 4'h9, 32'h44000022, 4'h1, 4'h0, 8'h22, 1'b1, 1'b1);
    add(1, 4'h9, 32'h44000022, 4'h1, 4'h1, 8'h22, 1'b0, 1'b1);
    add(1, 4'h9, 32'h44000022, 4'h0, 4'h0, 8'h22, 1'b0, 1'b0);
    add(1, 4'h9, 32'h44000022, 4'h8, 4'h0, 8'h44, 1'b0, 1'b1);
    add(1, 4'h0, 32'h44000022, 4'h8, 4'h0, 8'h44, 1'b1, 1'b1);
    add(1, 4'h0, 32'h00000000, 4'h8, 4'h0, 8'h44, 1'b1, 1'b1);
    add(1, 4'h0, 32'h00000000, 4'h8, 4'h8, 8'h44, 1'b0, 1'b1);
    add(1, 4'h0, 32'h00000000, 4'h0, 4'h0, 8'h44, 1'b0, 1'b0);
    for (int i = 0; i < v.size(); i++) begin
      step(v[i].rn, v[i].rq, v[i].wd);
      check("gnt", i, 32'(gnt), 32'(v[i].g));
      check("done", i, 32'(done), 32'(v[i].d));
      check("latch_d", i, 32'(latch_d), 32'(v[i].ld));
      check("latch_en", i, 32'(latch_en), 32'(v[i].en));
      check("busy", i, 32'(busy), 32'(v[i].bz));
    end
    step(0, 4'h0, 32'h0);
    step(0, 4'h0, 32'h0);
    n = 0;
    prev = '0;
    for (int c = 1; c <= 25; c++) begin
      step(1, 4'hF, 32'h44332211);
      if (gnt != 4'h0 && prev == 4'h0) begin
        exp_g = 4'h1 << (n % 4);
        check("rr_gnt", c, 32'(gnt), 32'(exp_g));
        check("rr_cycle", c, c, 1 + 5 * n);
        check("rr_data", c, 32'(latch_d), 32'((n % 4) + 1) * 32'h11);
        n++;
      end
      if ((done & ~gnt) != 4'h0) check("done_subset", c, 32'(done), 32'(done & gnt));
      prev = gnt;
    end
    check("rr_count", 0, n, 5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
